// File: rtl/pn_permute_stage.sv
// Registered 2x2 permuter cell: time-based arbitration with an alternating priority mode,
// routes winner to its desired port and deflects the loser. Optional macro: PN_AGE_INC_EN.
module pn_permute_stage #(
  parameter int FLIT_W   = 64,
  parameter int TIME_LSB = 0,
  parameter int DIR_BIT  = 63,
  parameter int CNT_W    = 16,
  parameter int TIME_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [FLIT_W-1:0] flit0_in,
  input  logic              valid0_in,
  input  logic [FLIT_W-1:0] flit1_in,
  input  logic              valid1_in,
  output logic [FLIT_W-1:0] flit0_out,
  output logic              valid0_out,
  output logic [FLIT_W-1:0] flit1_out,
  output logic              valid1_out,
  output logic              mode_out,
  output logic [CNT_W-1:0]  deflect_cnt
);

  localparam logic [TIME_W-1:0] MAX_TIME = '1;
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

`ifdef PN_AGE_INC_EN
  localparam logic [TIME_W-1:0] TIME_ONE = TIME_W'(1);

  // Untimed (0) and saturated flits keep their time field.
  function automatic logic [FLIT_W-1:0] age_inc(input logic v, input logic [FLIT_W-1:0] f);
    logic [FLIT_W-1:0] r;
    logic [TIME_W-1:0] t;
    r = f;
    t = f[TIME_LSB +: TIME_W];
    if (v && (t != '0) && (t != MAX_TIME)) t = t + TIME_ONE;
    r[TIME_LSB +: TIME_W] = t;
    return r;
  endfunction
`endif

  // Handshake: valid-only, no ready. The network is bufferless, so every valid
  // input is accepted each cycle and appears on exactly one output one cycle later.

  logic [FLIT_W-1:0] flit0_q, flit1_q, flit0_d, flit1_d;
  logic              valid0_q, valid1_q, valid0_d, valid1_d;
  logic              mode_q, mode_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [TIME_W-1:0] t0_raw, t1_raw, t0_arb, t1_arb;
  logic              swap, winner, win_dir, los_dir, win_v, los_v, deflect;
  logic [FLIT_W-1:0] win_flit, los_flit;

  always_comb begin
    t0_raw = valid0_in ? flit0_in[TIME_LSB +: TIME_W] : '0;
    t1_raw = valid1_in ? flit1_in[TIME_LSB +: TIME_W] : '0;
    t0_arb = (t0_raw == '0) ? MAX_TIME : t0_raw;
    t1_arb = (t1_raw == '0) ? MAX_TIME : t1_raw;

    swap = mode_q ? (t0_arb < t1_arb) : (t1_arb < t0_arb);
    // A lone valid flit must win even when its time reads as MAX_TIME.
    if (valid0_in ^ valid1_in) winner = valid1_in;
    else                       winner = mode_q ^ swap;

    win_flit = winner ? flit1_in  : flit0_in;
    win_v    = winner ? valid1_in : valid0_in;
    los_flit = winner ? flit0_in  : flit1_in;
    los_v    = winner ? valid0_in : valid1_in;
    win_dir  = win_flit[DIR_BIT];
    los_dir  = los_flit[DIR_BIT];

    if (win_dir) begin
      flit1_d  = win_flit;
      valid1_d = win_v;
      flit0_d  = los_flit;
      valid0_d = los_v;
    end else begin
      flit0_d  = win_flit;
      valid0_d = win_v;
      flit1_d  = los_flit;
      valid1_d = los_v;
    end

`ifdef PN_AGE_INC_EN
    flit0_d = age_inc(valid0_d, flit0_d);
    flit1_d = age_inc(valid1_d, flit1_d);
`endif

    deflect = valid0_in & valid1_in & (win_dir == los_dir);
    cnt_d   = (deflect && (cnt_q != CNT_MAX)) ? cnt_q + CNT_ONE : cnt_q;
    mode_d  = ~mode_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flit0_q  <= '0;
      flit1_q  <= '0;
      valid0_q <= 1'b0;
      valid1_q <= 1'b0;
      mode_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      flit0_q  <= flit0_d;
      flit1_q  <= flit1_d;
      valid0_q <= valid0_d;
      valid1_q <= valid1_d;
      mode_q   <= mode_d;
      cnt_q    <= cnt_d;
    end
  end

  assign flit0_out   = flit0_q;
  assign flit1_out   = flit1_q;
  assign valid0_out  = valid0_q;
  assign valid1_out  = valid1_q;
  assign mode_out    = mode_q;
  assign deflect_cnt = cnt_q;

endmodule

// File: tb/tb_pn_permute_stage.sv
// Self-checking bench for pn_permute_stage: directed scenarios plus randomized traffic
// against an age-ordering reference model. Honours PN_AGE_INC_EN when defined.
module tb_pn_permute_stage;

  localparam int FLIT_W = 64;
  localparam int CNT_W  = 8;
  localparam int TIME_W = 8;
  localparam int MAXT   = 255;

  logic              clk = 1'b0;
  logic              reset;
  logic [FLIT_W-1:0] flit0_in, flit1_in;
  logic              valid0_in, valid1_in;
  logic [FLIT_W-1:0] flit0_out, flit1_out;
  logic              valid0_out, valid1_out;
  logic              mode_out;
  logic [CNT_W-1:0]  deflect_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic              m_mode;
  int                m_cnt;
  logic [FLIT_W-1:0] e_f0, e_f1;
  logic              e_v0, e_v1;
  logic [2*FLIT_W+1:0] exp_q[$];

  pn_permute_stage #(.FLIT_W(FLIT_W), .TIME_LSB(0), .DIR_BIT(63), .CNT_W(CNT_W), .TIME_W(TIME_W)) dut (
    .clk(clk), .reset(reset),
    .flit0_in(flit0_in), .valid0_in(valid0_in),
    .flit1_in(flit1_in), .valid1_in(valid1_in),
    .flit0_out(flit0_out), .valid0_out(valid0_out),
    .flit1_out(flit1_out), .valid1_out(valid1_out),
    .mode_out(mode_out), .deflect_cnt(deflect_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, actual=running required=finished");
    $fatal(1, "timeout");
  end

  function automatic logic [FLIT_W-1:0] mk(input logic dir, input int t);
    logic [54:0] pay;
    pay = {$urandom(), $urandom()};
    return {dir, pay, t[7:0]};
  endfunction

  function automatic logic [FLIT_W-1:0] aged(input logic [FLIT_W-1:0] f);
    logic [FLIT_W-1:0] r;
    int t;
    r = f;
`ifdef PN_AGE_INC_EN
    t = int'(f[7:0]);
    if (t != 0 && t < MAXT) t = t + 1;
    r[7:0] = t[7:0];
`else
    t = 0;
`endif
    return r;
  endfunction

  // Drive one cycle (called at negedge), predict outputs, advance to next negedge.
  task automatic step(input logic [FLIT_W-1:0] f0, input logic v0,
                      input logic [FLIT_W-1:0] f1, input logic v1);
    int a0, a1, w;
    logic [FLIT_W-1:0] wf, lf;
    logic wv, lv;
    a0 = (v0 && f0[7:0] != 0) ? int'(f0[7:0]) : MAXT;
    a1 = (v1 && f1[7:0] != 0) ? int'(f1[7:0]) : MAXT;
    if (v0 && !v1)      w = 0;
    else if (v1 && !v0) w = 1;
    else if (a0 < a1)   w = 0;
    else if (a1 < a0)   w = 1;
    else                w = m_mode ? 1 : 0;
    wf = (w == 1) ? f1 : f0;  wv = (w == 1) ? v1 : v0;
    lf = (w == 1) ? f0 : f1;  lv = (w == 1) ? v0 : v1;
    if (wf[63]) begin e_f1 = aged(wf); e_v1 = wv; e_f0 = aged(lf); e_v0 = lv; end
    else        begin e_f0 = aged(wf); e_v0 = wv; e_f1 = aged(lf); e_v1 = lv; end
    flit0_in = f0; valid0_in = v0; flit1_in = f1; valid1_in = v1;
    @(posedge clk);
    @(negedge clk);
    m_mode = ~m_mode;
    if (v0 && v1 && (f0[63] == f1[63]) && m_cnt < 255) m_cnt = m_cnt + 1;
  endtask

  task automatic idle();
    step('0, 1'b0, '0, 1'b0);
  endtask

  task automatic align_mode(input logic m);
    if (m_mode != m) idle();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    valid0_in = 1'b0; valid1_in = 1'b0; flit0_in = '0; flit1_in = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    m_mode = 1'b0;
    m_cnt  = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (valid0_out !== 1'b0 || valid1_out !== 1'b0) begin
      errors++; $display("FAIL reset_valids: actual=%b%b required=00", valid0_out, valid1_out);
    end
    checks++;
    if (flit0_out !== '0 || flit1_out !== '0) begin
      errors++; $display("FAIL reset_flits: actual=%h/%h required=0/0", flit0_out, flit1_out);
    end
    checks++;
    if (mode_out !== 1'b0 || deflect_cnt !== '0) begin
      errors++; $display("FAIL reset_mode_cnt: actual=%b/%0d required=0/0", mode_out, deflect_cnt);
    end
  endtask

  task automatic test_single_flit();
    logic [FLIT_W-1:0] f;
    int c0;
    f = mk(1'b1, 5);
    c0 = m_cnt;
    step(f, 1'b1, mk(1'b0, 3), 1'b0);
    checks++;
    if (valid1_out !== 1'b1 || valid0_out !== 1'b0 || flit1_out !== aged(f)) begin
      errors++;
      $display("FAIL single_flit: actual v=%b%b f1=%h required v=10 f1=%h", valid1_out, valid0_out, flit1_out, aged(f));
    end
    checks++;
    if (deflect_cnt !== CNT_W'(c0)) begin
      errors++; $display("FAIL single_cnt: actual=%0d required=%0d", deflect_cnt, c0);
    end
  endtask

  task automatic test_older_wins();
    logic [FLIT_W-1:0] f0, f1;
    for (int m = 0; m < 2; m++) begin
      align_mode(m[0]);
      f0 = mk(1'b0, 9);
      f1 = mk(1'b0, 3);
      step(f0, 1'b1, f1, 1'b1);
      checks++;
      if (flit0_out !== aged(f1) || flit1_out !== aged(f0) || {valid0_out, valid1_out} !== 2'b11) begin
        errors++;
        $display("FAIL older_wins_m%0d: actual out0=%h out1=%h required out0=%h out1=%h", m, flit0_out, flit1_out, aged(f1), aged(f0));
      end
      checks++;
      if (deflect_cnt !== CNT_W'(m_cnt)) begin
        errors++; $display("FAIL older_wins_cnt_m%0d: actual=%0d required=%0d", m, deflect_cnt, m_cnt);
      end
    end
  endtask

  task automatic test_tie();
    logic [FLIT_W-1:0] f0, f1;
    int c0;
    align_mode(1'b0);
    c0 = int'(deflect_cnt);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (mode_out !== k[0]) begin
        errors++; $display("FAIL tie_mode%0d: actual=%b required=%b", k, mode_out, k[0]);
      end
      f0 = mk(1'b1, 7);
      f1 = mk(1'b1, 7);
      step(f0, 1'b1, f1, 1'b1);
      checks++;
      if (flit1_out !== aged(k == 0 ? f0 : f1) || flit0_out !== aged(k == 0 ? f1 : f0)) begin
        errors++;
        $display("FAIL tie_winner%0d: actual out1=%h out0=%h required out1=%h", k, flit1_out, flit0_out, aged(k == 0 ? f0 : f1));
      end
    end
    checks++;
    if (int'(deflect_cnt) !== c0 + 2) begin
      errors++; $display("FAIL tie_cnt: actual=%0d required=%0d", deflect_cnt, c0 + 2);
    end
  endtask

  task automatic test_time_edges();
    logic [FLIT_W-1:0] f0, f1;
    f1 = mk(1'b0, MAXT);
    step(mk(1'b1, 2), 1'b0, f1, 1'b1);
    checks++;
    if (valid0_out !== 1'b1 || valid1_out !== 1'b0 || flit0_out !== f1) begin
      errors++; $display("FAIL max_time_lone: actual v0=%b f0=%h required v0=1 f0=%h", valid0_out, flit0_out, f1);
    end
    for (int m = 0; m < 2; m++) begin
      align_mode(m[0]);
      f0 = mk(1'b0, 0);
      f1 = mk(1'b1, 4);
      step(f0, 1'b1, f1, 1'b1);
      checks++;
      if (flit1_out !== aged(f1) || flit0_out !== aged(f0)) begin
        errors++;
        $display("FAIL time0_loses_m%0d: actual out0=%h out1=%h required out0=%h out1=%h", m, flit0_out, flit1_out, aged(f0), aged(f1));
      end
    end
  endtask

  task automatic test_age();
    int tin[3];
    int tout;
    logic [FLIT_W-1:0] f;
    tin[0] = 4; tin[1] = MAXT; tin[2] = 0;
    for (int i = 0; i < 3; i++) begin
`ifdef PN_AGE_INC_EN
      tout = (tin[i] == 4) ? 5 : tin[i];
`else
      tout = tin[i];
`endif
      f = mk(1'b0, tin[i]);
      step(f, 1'b1, '0, 1'b0);
      checks++;
      if (valid0_out !== 1'b1 || int'(flit0_out[7:0]) !== tout || flit0_out[63:8] !== f[63:8]) begin
        errors++; $display("FAIL age_time%0d: actual v=%b t=%0d required v=1 t=%0d", tin[i], valid0_out, flit0_out[7:0], tout);
      end
    end
  endtask

  task automatic test_random();
    logic [FLIT_W-1:0] f0, f1;
    logic v0, v1;
    logic [2*FLIT_W+1:0] e;
    int bad;
    bad = 0;
    for (int n = 0; n < 300; n++) begin
      v0 = ($urandom_range(0, 3) != 0);
      v1 = ($urandom_range(0, 3) != 0);
      f0 = mk($urandom_range(0, 1), ($urandom_range(0, 9) == 0) ? MAXT : $urandom_range(0, 12));
      f1 = mk($urandom_range(0, 1), ($urandom_range(0, 9) == 0) ? MAXT : $urandom_range(0, 12));
      checks++;
      if (mode_out !== m_mode) begin
        errors++; $display("FAIL rand_mode%0d: actual=%b required=%b", n, mode_out, m_mode);
      end
      step(f0, v0, f1, v1);
      exp_q.push_back({e_v1, e_f1, e_v0, e_f0});
      e = exp_q.pop_front();
      checks++;
      if ({valid1_out, valid0_out} !== {e[2*FLIT_W+1], e[FLIT_W]} ||
          (valid0_out && flit0_out !== e[FLIT_W-1:0]) ||
          (valid1_out && flit1_out !== e[2*FLIT_W:FLIT_W+1]) ||
          deflect_cnt !== CNT_W'(m_cnt)) begin
        errors++;
        if (bad < 10)
          $display("FAIL rand%0d: actual v=%b%b o0=%h o1=%h cnt=%0d required v=%b%b o0=%h o1=%h cnt=%0d",
                   n, valid1_out, valid0_out, flit0_out, flit1_out, deflect_cnt,
                   e[2*FLIT_W+1], e[FLIT_W], e[FLIT_W-1:0], e[2*FLIT_W:FLIT_W+1], m_cnt);
        bad++;
      end
    end
  endtask

  task automatic test_saturation();
    for (int n = 0; n < 270; n++) step(mk(1'b0, 6), 1'b1, mk(1'b0, 8), 1'b1);
    checks++;
    if (deflect_cnt !== 8'hFF) begin
      errors++; $display("FAIL saturation: actual=%0d required=255", deflect_cnt);
    end
  endtask

  task automatic test_reset_mid();
    flit0_in = mk(1'b0, 3); valid0_in = 1'b1;
    flit1_in = mk(1'b1, 4); valid1_in = 1'b1;
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (valid0_out !== 1'b0 || valid1_out !== 1'b0 || flit0_out !== '0 || flit1_out !== '0 ||
        mode_out !== 1'b0 || deflect_cnt !== '0) begin
      errors++;
      $display("FAIL reset_mid: actual v=%b%b mode=%b cnt=%0d required v=00 mode=0 cnt=0",
               valid0_out, valid1_out, mode_out, deflect_cnt);
    end
    do_reset();
    checks++;
    if (mode_out !== 1'b0) begin
      errors++; $display("FAIL reset_release_mode: actual=%b required=0", mode_out);
    end
  endtask

  initial begin
    reset = 1'b1;
    valid0_in = 1'b0; valid1_in = 1'b0; flit0_in = '0; flit1_in = '0;
    m_mode = 1'b0; m_cnt = 0;
    test_reset();
    test_single_flit();
    test_older_wins();
    test_tie();
    test_time_edges();
    test_age();
    test_random();
    test_saturation();
    test_reset_mid();
    test_single_flit();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
